// File: rtl/minimig_mem_pkg.sv
// -----------------------------------------------------------------------------
// minimig_mem_pkg
// Shared types and constants for the SRAM-to-req/ack memory adapter.
//   mem_state_e    : adapter FSM states (IDLE, REQ)
//   BE_*           : active-high byte-enable encodings {hi,lo}
//   RD_TIMEOUT_VAL : read data returned to the bridge when a read times out
// -----------------------------------------------------------------------------
package minimig_mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } mem_state_e;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_WORD = 2'b11;

  localparam logic [15:0] RD_TIMEOUT_VAL = 16'hFFFF;

endpackage

// File: rtl/sram_mem_adapter_timer.sv
// -----------------------------------------------------------------------------
// mem_req_timer
// Loadable cycle counter that measures how long a memory request has been
// outstanding.
//   clk, reset : clock and asynchronous active-high reset
//   clr_i      : load zero (request being issued)
//   inc_i      : count one more cycle without acknowledge
//   term_o     : high in the last allowed cycle of the request
// -----------------------------------------------------------------------------
module mem_req_timer #(
  parameter int TIMEOUT = 63
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The count starts at zero in the first request cycle, so holding
  // TIMEOUT-1 means this is cycle number TIMEOUT: the abort edge is the one
  // on which the count would reach TIMEOUT.
  assign term_o = (count_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/sram_mem_adapter.sv
// -----------------------------------------------------------------------------
// sram_mem_adapter
// Turns the bridge's level-style, active-low SRAM strobes into single-shot
// requests on a synchronous req/ack memory port, holds read data for the
// bridge, and flags a sticky error if the memory never acknowledges.
//   clk, reset            : clock and asynchronous active-high reset
//   _oe, _we, _bhe, _ble  : active-low SRAM strobes from the bridge
//   address, data         : word address and write data from the bridge
//   ramdata_in            : read data held for the bridge
//   mem_req/we/addr/be/wdata : request to the memory controller
//   mem_ack, mem_rdata    : completion strobe and read data from memory
//   busy                  : request outstanding
//   err                   : sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module sram_mem_adapter
  import minimig_mem_pkg::*;
#(
  parameter int          ADDR_W  = 21,
  parameter int          TIMEOUT = 63,
  parameter logic [15:0] RD_IDLE = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              _oe,
  input  logic              _we,
  input  logic              _bhe,
  input  logic              _ble,
  input  logic [ADDR_W-1:0] address,
  input  logic [15:0]       data,
  output logic [15:0]       ramdata_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_be,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic              err
);

  localparam int KW = ADDR_W + 3;

  mem_state_e        state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [1:0]        mem_be_q, mem_be_d;
  logic [15:0]       mem_wdata_q, mem_wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [KW-1:0]     key_q, key_d;
  logic              key_valid_q, key_valid_d;

  logic              wr_act;
  logic              rd_act;
  logic              new_acc;
  logic [KW-1:0]     key;
  logic              timer_clr;
  logic              timer_inc;
  logic              timer_term;

  // The bridge holds its strobes for many cycles; the key remembers the
  // access already issued so a held strobe produces exactly one request.
  assign wr_act  = !_we && (!_bhe || !_ble);
  assign rd_act  = !_oe && !wr_act;
  assign key     = {address, wr_act, _bhe, _ble};
  assign new_acc = (wr_act || rd_act) && (!key_valid_q || (key != key_q));

  mem_req_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (timer_clr),
    .inc_i  (timer_inc),
    .term_o (timer_term)
  );

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    timer_clr   = 1'b0;
    timer_inc   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (new_acc) begin
          state_d     = REQ;
          mem_addr_d  = address;
          mem_we_d    = wr_act;
          mem_be_d    = wr_act ? {!_bhe, !_ble} : BE_WORD;
          mem_wdata_d = data;
          key_d       = key;
          key_valid_d = 1'b1;
          timer_clr   = 1'b1;
        end
      end
      REQ: begin
        // Ack is tested first so it wins over a coincident timeout.
        if (mem_ack) begin
          state_d = IDLE;
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end
        end else if (timer_term) begin
          state_d = IDLE;
          err_d   = 1'b1;
          if (!mem_we_q) begin
            rdata_d = RD_TIMEOUT_VAL;
          end
        end else begin
          timer_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Both strobes released ends the bridge access, so the same access
    // repeated afterwards must be issued again.
    if (_oe && _we) begin
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= BE_NONE;
      mem_wdata_q <= '0;
      rdata_q     <= RD_IDLE;
      err_q       <= 1'b0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
    end
  end

  // Request and busy come straight from the state register, so an
  // asynchronous reset drops them immediately.
  assign mem_req    = (state_q == REQ);
  assign busy       = (state_q == REQ);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;
  assign ramdata_in = rdata_q;
  assign err        = err_q;

endmodule

// File: doc/sram_mem_adapter.md
Name: sram_mem_adapter

Overview:
- Sits directly downstream of the chipset SRAM bridge.
- Converts its level-style active-low SRAM strobes (_oe, _we, _bhe, _ble, 21-bit word address, 16-bit write data) into single-shot requests on a synchronous req/ack memory port (BRAM/SDRAM controller side).
- Holds returned read data stable on ramdata_in for the bridge until the next read completes.
- Reports busy, plus a sticky timeout error if the memory side never acknowledges.

Parameters:
- ADDR_W, 21, word address width (address[21:1]).
- TIMEOUT, 63, max cycles from mem_req assertion to mem_ack before abort; counter width is $clog2(TIMEOUT+1).
- RD_IDLE, 16'h0000, value of ramdata_in after reset.

Ports:
- clk  in  1  system clock (28 MHz domain, same as bridge)
- reset  in  1  asynchronous active-high reset
- _oe  in  1  SRAM output enable from bridge, active low
- _we  in  1  SRAM write enable from bridge, active low
- _bhe  in  1  upper byte enable, active low
- _ble  in  1  lower byte enable, active low
- address  in  ADDR_W  word address
- data  in  16  write data from bridge
- ramdata_in  out  16  read data returned to bridge
- mem_req  out  1  request to memory controller
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  latched address
- mem_be  out  2  byte enables {hi,lo}, active high
- mem_wdata  out  16  latched write data
- mem_ack  in  1  one-cycle completion strobe from memory
- mem_rdata  in  16  read data, valid in the mem_ack cycle
- busy  out  1  high in REQ state
- err  out  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset values (asynchronous):
  - State is IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
  - ramdata_in=RD_IDLE, busy=0, err=0.
  - last_key is invalid.
- Decode, combinational:
  - wr_act = !_we && (!_bhe || !_ble).
  - rd_act = !_oe && !wr_act. Write takes priority if both strobes are low.
  - key = {address, wr_act, _bhe, _ble}.
  - new_acc = (wr_act || rd_act) && (last_key invalid || key != last_key).
  - When both strobes are high, last_key is invalidated, so a repeated access to the same address re-issues.
- States: IDLE, REQ.
- IDLE:
  - On new_acc, latch the following and go to REQ on the next edge:
    - mem_addr = address
    - mem_we = wr_act
    - mem_be = wr_act ? {!_bhe, !_ble} : 2'b11
    - mem_wdata = data
    - last_key = key
  - Also on that edge: mem_req=1, busy=1, timeout counter=0.
- REQ:
  - mem_req is held high and all mem_* outputs are stable until mem_ack.
  - On mem_ack:
    - mem_req=0, busy=0, go to IDLE.
    - For a read, ramdata_in <= mem_rdata on the same edge.
    - For a write, ramdata_in is unchanged.
  - Input strobe or address changes during REQ are ignored. The key is re-evaluated in IDLE, so a changed access issues right after completion.
  - The counter increments every REQ cycle without mem_ack. If it reaches TIMEOUT without mem_ack, then on that edge:
    - mem_req=0, err=1, go to IDLE.
    - ramdata_in=16'hFFFF if the access was a read.
  - If mem_ack and the timeout arrive in the same cycle, ack wins and err is not set.
- mem_ack in IDLE is ignored.
- Latency: request asserted 1 cycle after strobe assertion; ramdata_in updated 1 cycle after mem_ack.
- Back-to-back: a new access can issue on the cycle after returning to IDLE. The minimum repeat interval is 2 cycles plus memory latency.
- Reset mid-REQ: mem_req drops immediately (asynchronously). The memory side must tolerate an abandoned request.

Decomposition:
- Shared package minimig_mem_pkg holds:
  - state enum {IDLE, REQ}
  - byte-enable constants BE_NONE=2'b00, BE_LO=2'b01, BE_HI=2'b10, BE_WORD=2'b11
  - timeout error read value 16'hFFFF
- One sub-module is natural: mem_req_timer (loadable counter with TIMEOUT terminal flag).

Test Plan:
- Read: address=21'h00123, _oe low, mem_ack 3 cycles after mem_req with mem_rdata=16'hBEEF -> one request with mem_we=0 and mem_be=2'b11; ramdata_in=16'hBEEF one cycle after ack; no second request while _oe stays low.
- Byte write: _we=0, _bhe=0, _ble=1, data=16'hA5xx, address=21'h1FFFFF -> mem_we=1, mem_be=2'b10, mem_wdata=16'hA5xx, mem_addr=21'h1FFFFF; ramdata_in unchanged.
- Address change under held _oe: 21'h10 then 21'h11 while in REQ -> second request issues exactly 1 cycle after the first ack, with mem_addr=21'h11.
- Timeout: no mem_ack with TIMEOUT=63 -> mem_req drops after 63 REQ cycles; err=1 stays set; ramdata_in=16'hFFFF; the next access still completes normally.
- Ack and timeout coincide: mem_ack in the terminal cycle -> err stays 0; data captured.
- Reset during REQ: reset pulsed while mem_req=1 -> all outputs at reset values immediately; an identical access after reset re-issues because last_key is invalid.
